// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC/BadVAddr/Count/Compare/PRId/Config, timer and interrupt request.
// Define CP0_TLB_EN to add Index/Random/EntryLo0/1/Context/PageMask/Wired/EntryHi.
module cp0_regfile #(
  parameter int unsigned TLB_ENTRIES = 32,
  parameter int unsigned COUNT_DIV   = 2,
  parameter logic [31:0] PRID_VAL    = 32'h00004220
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_bva_valid,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [5:0]  ext_int,
  output logic        int_req,
  output logic [31:0] epc,
  output logic        exl
);

  if (TLB_ENTRIES < 2 || TLB_ENTRIES > 64 || COUNT_DIV < 1 || COUNT_DIV > 16) begin : g_bad_param
    $error("cp0_regfile: TLB_ENTRIES or COUNT_DIV out of range");
  end

  localparam int unsigned PreW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(COUNT_DIV - 1);

  localparam logic [4:0] AddrIndex    = 5'd0;
  localparam logic [4:0] AddrRandom   = 5'd1;
  localparam logic [4:0] AddrEntryLo0 = 5'd2;
  localparam logic [4:0] AddrEntryLo1 = 5'd3;
  localparam logic [4:0] AddrContext  = 5'd4;
  localparam logic [4:0] AddrPageMask = 5'd5;
  localparam logic [4:0] AddrWired    = 5'd6;
  localparam logic [4:0] AddrBadVAddr = 5'd8;
  localparam logic [4:0] AddrCount    = 5'd9;
  localparam logic [4:0] AddrEntryHi  = 5'd10;
  localparam logic [4:0] AddrCompare  = 5'd11;
  localparam logic [4:0] AddrStatus   = 5'd12;
  localparam logic [4:0] AddrCause    = 5'd13;
  localparam logic [4:0] AddrEpc      = 5'd14;
  localparam logic [4:0] AddrPrid     = 5'd15;
  localparam logic [4:0] AddrConfig   = 5'd16;

`ifdef CP0_TLB_EN
  localparam logic [2:0] ConfigMt = 3'd1;
`else
  localparam logic [2:0] ConfigMt = 3'd0;
`endif

  logic [7:0]      status_im_q, status_im_d;
  logic            status_exl_q, status_exl_d;
  logic            status_ie_q, status_ie_d;
  logic            cause_bd_q, cause_bd_d;
  logic            cause_ti_q, cause_ti_d;
  logic [5:0]      cause_ip_hw_q, cause_ip_hw_d;
  logic [1:0]      cause_ip_sw_q, cause_ip_sw_d;
  logic [4:0]      cause_exc_q, cause_exc_d;
  logic [31:0]     epc_q, epc_d;
  logic [31:0]     badvaddr_q, badvaddr_d;
  logic [31:0]     count_q, count_d;
  logic [31:0]     compare_q, compare_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic [2:0]      config_k0_q, config_k0_d;

`ifdef CP0_TLB_EN
  localparam int unsigned TLB_INDEX = $clog2(TLB_ENTRIES);
  localparam logic [TLB_INDEX-1:0] RandomMax = TLB_INDEX'(TLB_ENTRIES - 1);

  logic [TLB_INDEX-1:0] index_q, index_d;
  logic [TLB_INDEX-1:0] random_q, random_d;
  logic [TLB_INDEX-1:0] wired_q, wired_d;
  logic [25:0]          entrylo0_q, entrylo0_d;
  logic [25:0]          entrylo1_q, entrylo1_d;
  logic [8:0]           context_pte_q, context_pte_d;
  logic [18:0]          context_bad_q, context_bad_d;
  logic [11:0]          pagemask_q, pagemask_d;
  logic [18:0]          entryhi_vpn2_q, entryhi_vpn2_d;
  logic [7:0]           entryhi_asid_q, entryhi_asid_d;
`endif

  // Exception beats ERET beats MTC0; a losing event has no effect at all.
  logic wr_en;
  assign wr_en = we & ~exc_valid & ~eret;

  always_comb begin
    status_im_d   = status_im_q;
    status_exl_d  = status_exl_q;
    status_ie_d   = status_ie_q;
    cause_bd_d    = cause_bd_q;
    cause_ti_d    = cause_ti_q;
    cause_ip_sw_d = cause_ip_sw_q;
    cause_exc_d   = cause_exc_q;
    epc_d         = epc_q;
    badvaddr_d    = badvaddr_q;
    compare_d     = compare_q;
    config_k0_d   = config_k0_q;
    cause_ip_hw_d = {ext_int[5] | cause_ti_q, ext_int[4:0]};
`ifdef CP0_TLB_EN
    index_d        = index_q;
    wired_d        = wired_q;
    entrylo0_d     = entrylo0_q;
    entrylo1_d     = entrylo1_q;
    context_pte_d  = context_pte_q;
    context_bad_d  = context_bad_q;
    pagemask_d     = pagemask_q;
    entryhi_vpn2_d = entryhi_vpn2_q;
    entryhi_asid_d = entryhi_asid_q;
`endif

    if (wr_en && wa == AddrCount) begin
      count_d = wdata;
      presc_d = '0;
    end else if (presc_q == PreLast) begin
      count_d = count_q + 32'd1;
      presc_d = '0;
    end else begin
      count_d = count_q;
      presc_d = presc_q + PreW'(1);
    end

    if (wr_en && wa == AddrCompare) begin
      cause_ti_d = 1'b0;
    end else if (count_d == compare_q) begin
      cause_ti_d = 1'b1;
    end

`ifdef CP0_TLB_EN
    if (wr_en && wa == AddrWired) begin
      wired_d  = wdata[TLB_INDEX-1:0];
      random_d = RandomMax;
    end else if (random_q <= wired_q || random_q == '0) begin
      random_d = RandomMax;
    end else begin
      random_d = random_q - TLB_INDEX'(1);
    end
`endif

    if (exc_valid) begin
      status_exl_d = 1'b1;
      cause_exc_d  = exc_code;
      // A nested exception keeps the original return point.
      if (!status_exl_q) begin
        epc_d      = exc_bd ? exc_pc - 32'd4 : exc_pc;
        cause_bd_d = exc_bd;
      end
      if (exc_bva_valid) begin
        badvaddr_d = exc_badvaddr;
`ifdef CP0_TLB_EN
        entryhi_vpn2_d = exc_badvaddr[31:13];
        context_bad_d  = exc_badvaddr[31:13];
`endif
      end
    end else if (eret) begin
      status_exl_d = 1'b0;
    end else if (we) begin
      case (wa)
        AddrCompare: compare_d = wdata;
        AddrStatus: begin
          status_im_d  = wdata[15:8];
          status_exl_d = wdata[1];
          status_ie_d  = wdata[0];
        end
        AddrCause:  cause_ip_sw_d = wdata[9:8];
        AddrEpc:    epc_d = wdata;
        AddrConfig: config_k0_d = wdata[2:0];
`ifdef CP0_TLB_EN
        AddrIndex:    index_d = wdata[TLB_INDEX-1:0];
        AddrEntryLo0: entrylo0_d = wdata[25:0];
        AddrEntryLo1: entrylo1_d = wdata[25:0];
        AddrContext:  context_pte_d = wdata[31:23];
        AddrPageMask: pagemask_d = wdata[24:13];
        AddrEntryHi: begin
          entryhi_vpn2_d = wdata[31:13];
          entryhi_asid_d = wdata[7:0];
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_im_q   <= '0;
      status_exl_q  <= 1'b0;
      status_ie_q   <= 1'b0;
      cause_bd_q    <= 1'b0;
      cause_ti_q    <= 1'b0;
      cause_ip_hw_q <= '0;
      cause_ip_sw_q <= '0;
      cause_exc_q   <= '0;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      count_q       <= '0;
      compare_q     <= '0;
      presc_q       <= '0;
      config_k0_q   <= 3'd3;
`ifdef CP0_TLB_EN
      index_q        <= '0;
      random_q       <= RandomMax;
      wired_q        <= '0;
      entrylo0_q     <= '0;
      entrylo1_q     <= '0;
      context_pte_q  <= '0;
      context_bad_q  <= '0;
      pagemask_q     <= '0;
      entryhi_vpn2_q <= '0;
      entryhi_asid_q <= '0;
`endif
    end else begin
      status_im_q   <= status_im_d;
      status_exl_q  <= status_exl_d;
      status_ie_q   <= status_ie_d;
      cause_bd_q    <= cause_bd_d;
      cause_ti_q    <= cause_ti_d;
      cause_ip_hw_q <= cause_ip_hw_d;
      cause_ip_sw_q <= cause_ip_sw_d;
      cause_exc_q   <= cause_exc_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
      count_q       <= count_d;
      compare_q     <= compare_d;
      presc_q       <= presc_d;
      config_k0_q   <= config_k0_d;
`ifdef CP0_TLB_EN
      index_q        <= index_d;
      random_q       <= random_d;
      wired_q        <= wired_d;
      entrylo0_q     <= entrylo0_d;
      entrylo1_q     <= entrylo1_d;
      context_pte_q  <= context_pte_d;
      context_bad_q  <= context_bad_d;
      pagemask_q     <= pagemask_d;
      entryhi_vpn2_q <= entryhi_vpn2_d;
      entryhi_asid_q <= entryhi_asid_d;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    case (ra)
      AddrBadVAddr: rdata = badvaddr_q;
      AddrCount:    rdata = count_q;
      AddrCompare:  rdata = compare_q;
      AddrStatus:   rdata = {9'b0, 1'b1, 6'b0, status_im_q, 6'b0, status_exl_q, status_ie_q};
      AddrCause:    rdata = {cause_bd_q, cause_ti_q, 14'b0, cause_ip_hw_q, cause_ip_sw_q, 1'b0,
                             cause_exc_q, 2'b0};
      AddrEpc:      rdata = epc_q;
      AddrPrid:     rdata = PRID_VAL;
      AddrConfig:   rdata = {1'b1, 21'b0, ConfigMt, 4'b0, config_k0_q};
`ifdef CP0_TLB_EN
      AddrIndex:    rdata = 32'(index_q);
      AddrRandom:   rdata = 32'(random_q);
      AddrWired:    rdata = 32'(wired_q);
      AddrEntryLo0: rdata = {6'b0, entrylo0_q};
      AddrEntryLo1: rdata = {6'b0, entrylo1_q};
      AddrContext:  rdata = {context_pte_q, context_bad_q, 4'b0};
      AddrPageMask: rdata = {7'b0, pagemask_q, 13'b0};
      AddrEntryHi:  rdata = {entryhi_vpn2_q, 5'b0, entryhi_asid_q};
`endif
      default: rdata = '0;
    endcase
  end

  assign int_req = status_ie_q & ~status_exl_q &
                   (|({cause_ip_hw_q, cause_ip_sw_q} & status_im_q));
  assign epc     = epc_q;
  assign exl     = status_exl_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: whole-register reference model, directed and random stimulus.
module tb_cp0_regfile;
  localparam int unsigned TLB_ENTRIES = 32;
  localparam int unsigned COUNT_DIV   = 2;
  localparam logic [31:0] PRID_VAL    = 32'h00004220;
  localparam int unsigned IdxSpan     = 1 << $clog2(TLB_ENTRIES);
  localparam logic [31:0] StMask      = 32'h0000FF03;
`ifdef CP0_TLB_EN
  localparam logic [31:0] CfgRst = 32'h80000083;
  localparam bit          TlbEn  = 1'b1;
`else
  localparam logic [31:0] CfgRst = 32'h80000003;
  localparam bit          TlbEn  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra, wa, exc_code;
  logic [31:0] rdata, wdata, exc_pc, exc_badvaddr, epc;
  logic        we, exc_valid, exc_bd, exc_bva_valid, eret, int_req, exl;
  logic [5:0]  ext_int;

  cp0_regfile #(
    .TLB_ENTRIES(TLB_ENTRIES),
    .COUNT_DIV  (COUNT_DIV),
    .PRID_VAL   (PRID_VAL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ra           (ra),
    .rdata        (rdata),
    .we           (we),
    .wa           (wa),
    .wdata        (wdata),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .exc_bd       (exc_bd),
    .exc_bva_valid(exc_bva_valid),
    .exc_badvaddr (exc_badvaddr),
    .eret         (eret),
    .ext_int      (ext_int),
    .int_req      (int_req),
    .epc          (epc),
    .exl          (exl)
  );

  always #5 clk = ~clk;

  // chk bits: 0 rdata, 1 int_req, 2 epc, 3 exl
  typedef struct {
    string       name;
    bit [3:0]    chk;
    logic [31:0] rd;
    logic        ir;
    logic [31:0] ep;
    logic        ex;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en   = 1'b0;

  logic [31:0] m_st, m_ca, m_epc, m_bva, m_cnt, m_cmp, m_cfg;
  int unsigned m_pre, m_rnd, m_wired;

  task automatic model_reset();
    m_st = 32'h00400000; m_ca = '0; m_epc = '0; m_bva = '0;
    m_cnt = '0; m_cmp = '0; m_cfg = CfgRst; m_pre = 0;
    m_rnd = TLB_ENTRIES - 1; m_wired = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd1:    return TlbEn ? 32'(m_rnd) : 32'h0;
      5'd6:    return TlbEn ? 32'(m_wired) : 32'h0;
      5'd8:    return m_bva;
      5'd9:    return m_cnt;
      5'd11:   return m_cmp;
      5'd12:   return m_st;
      5'd13:   return m_ca;
      5'd14:   return m_epc;
      5'd15:   return PRID_VAL;
      5'd16:   return m_cfg;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    return m_st[0] & ~m_st[1] & (|(m_ca[15:8] & m_st[15:8]));
  endfunction

  // Advance the model by one clock using the inputs presented before the edge.
  task automatic model_step();
    logic [31:0] ca_old;
    bit wr, ti;
    if (reset) begin
      model_reset();
      return;
    end
    ca_old = m_ca;
    wr = we && !exc_valid && !eret;
    if (wr && wa == 5'd9) begin
      m_cnt = wdata; m_pre = 0;
    end else if (m_pre == COUNT_DIV - 1) begin
      m_pre = 0; m_cnt = m_cnt + 1;
    end else begin
      m_pre = m_pre + 1;
    end
    ti = ca_old[30];
    if (wr && wa == 5'd11) ti = 1'b0;
    else if (m_cnt == m_cmp) ti = 1'b1;
    if (wr && wa == 5'd6) begin
      m_wired = wdata % IdxSpan; m_rnd = TLB_ENTRIES - 1;
    end else if (m_rnd <= m_wired || m_rnd == 0) begin
      m_rnd = TLB_ENTRIES - 1;
    end else begin
      m_rnd = m_rnd - 1;
    end
    if (exc_valid) begin
      if (!m_st[1]) begin
        m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
        m_ca[31] = exc_bd;
      end
      m_st[1] = 1'b1;
      m_ca[6:2] = exc_code;
      if (exc_bva_valid) m_bva = exc_badvaddr;
    end else if (eret) begin
      m_st[1] = 1'b0;
    end else if (wr) begin
      case (wa)
        5'd11: m_cmp = wdata;
        5'd12: m_st = (m_st & ~StMask) | (wdata & StMask);
        5'd13: m_ca = (m_ca & ~32'h300) | (wdata & 32'h300);
        5'd14: m_epc = wdata;
        5'd16: m_cfg = (m_cfg & ~32'h7) | (wdata & 32'h7);
        default: ;
      endcase
    end
    m_ca[15:10] = {ext_int[5] | ca_old[30], ext_int[4:0]};
    m_ca[30] = ti;
  endtask

  task automatic push_lit(input string nm, input bit [3:0] c, input logic [31:0] rd,
                          input logic ir, input logic [31:0] ep, input logic ex);
    exp_t e;
    e.name = nm; e.chk = c; e.rd = rd; e.ir = ir; e.ep = ep; e.ex = ex;
    exp_q.push_back(e);
  endtask

  task automatic tick(input string nm);
    if (chk_en) push_lit(nm, 4'hF, m_read(ra), m_int(), m_epc, m_st[1]);
    @(posedge clk);
    model_step();
    #1;
    we = 1'b0; exc_valid = 1'b0; eret = 1'b0; exc_bva_valid = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input string nm);
    we = 1'b1; wa = a; wdata = d;
    tick(nm);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk[0]) begin
        n_checks++;
        if (rdata !== mon_e.rd) begin
          n_errors++;
          $display("FAIL %s rdata(ra=%0d): got %h want %h", mon_e.name, ra, rdata, mon_e.rd);
        end
      end
      if (mon_e.chk[1]) begin
        n_checks++;
        if (int_req !== mon_e.ir) begin
          n_errors++;
          $display("FAIL %s int_req: got %b want %b", mon_e.name, int_req, mon_e.ir);
        end
      end
      if (mon_e.chk[2]) begin
        n_checks++;
        if (epc !== mon_e.ep) begin
          n_errors++;
          $display("FAIL %s epc: got %h want %h", mon_e.name, epc, mon_e.ep);
        end
      end
      if (mon_e.chk[3]) begin
        n_checks++;
        if (exl !== mon_e.ex) begin
          n_errors++;
          $display("FAIL %s exl: got %b want %b", mon_e.name, exl, mon_e.ex);
        end
      end
    end
  end

  initial begin
    int sel;
    reset = 1'b1; ra = '0; we = 1'b0; wa = '0; wdata = '0; exc_valid = 1'b0;
    exc_code = '0; exc_pc = '0; exc_bd = 1'b0; exc_bva_valid = 1'b0; exc_badvaddr = '0;
    eret = 1'b0; ext_int = '0;
    model_reset();
    @(posedge clk); #1;
    tick("rst0");
    chk_en = 1'b1;
    ra = 5'd12; push_lit("rst_status", 4'hF, 32'h00400000, 1'b0, 32'h0, 1'b0); tick("rst");
    ra = 5'd16; push_lit("rst_config", 4'h1, CfgRst, 1'b0, 32'h0, 1'b0); tick("rst");
    ra = 5'd15; push_lit("rst_prid", 4'h1, PRID_VAL, 1'b0, 32'h0, 1'b0); tick("rst");
    reset = 1'b0;

    // Timer: Compare=5, Count=0, IM7 and IE set
    mtc0(5'd12, 32'h00008001, "wr_status");
    mtc0(5'd11, 32'd5, "wr_compare");
    mtc0(5'd9, 32'd0, "wr_count");
    ra = 5'd13;
    for (int k = 1; k <= 12; k++) begin
      if (k == 10) push_lit("ti_not_yet", 4'h3, 32'h00000000, 1'b0, 32'h0, 1'b0);
      if (k == 11) push_lit("ti_set", 4'h3, 32'h40000000, 1'b0, 32'h0, 1'b0);
      if (k == 12) push_lit("timer_int", 4'h3, 32'h40008000, 1'b1, 32'h0, 1'b0);
      tick("timer");
    end
    mtc0(5'd11, 32'h00010000, "wr_compare2");
    push_lit("ti_clear", 4'h1, 32'h00008000, 1'b0, 32'h0, 1'b0); tick("ti_clr");
    push_lit("timer_int_clear", 4'h3, 32'h00000000, 1'b0, 32'h0, 1'b0); tick("ti_clr");

    // Exception in a delay slot, then a nested one
    ra = 5'd14; exc_valid = 1'b1; exc_bd = 1'b1; exc_pc = 32'hBFC00104; exc_code = 5'h04;
    tick("exc1");
    push_lit("exc1_epc", 4'hF, 32'hBFC00100, 1'b0, 32'hBFC00100, 1'b1); tick("exc1");
    ra = 5'd13; push_lit("exc1_cause", 4'h1, 32'h80000010, 1'b0, 32'h0, 1'b0); tick("exc1");
    exc_valid = 1'b1; exc_bd = 1'b0; exc_pc = 32'h80000000; exc_code = 5'h08; tick("exc2");
    push_lit("exc2_cause", 4'h1, 32'h80000020, 1'b0, 32'h0, 1'b0); ra = 5'd13; tick("exc2");
    ra = 5'd14; push_lit("exc2_epc_held", 4'hD, 32'hBFC00100, 1'b0, 32'hBFC00100, 1'b1);
    tick("exc2");
    eret = 1'b1; tick("eret1");
    push_lit("eret1_exl", 4'h8, 32'h0, 1'b0, 32'h0, 1'b0); tick("eret1");

    // Same-cycle exception, eret and MTC0 Status=0
    exc_valid = 1'b1; exc_pc = 32'h00000100; exc_code = 5'h0C; eret = 1'b1;
    we = 1'b1; wa = 5'd12; wdata = 32'h0; tick("prio");
    ra = 5'd12; push_lit("prio_only_exc", 4'hD, 32'h00408003, 1'b0, 32'h00000100, 1'b1);
    tick("prio");
    eret = 1'b1; tick("prio_eret");
    push_lit("prio_eret_exl", 4'h8, 32'h0, 1'b0, 32'h0, 1'b0); tick("prio_eret");

    // External interrupt on IP4
    mtc0(5'd12, 32'h00001001, "wr_status_im4");
    ext_int = 6'b000100;
    push_lit("ext_int_pre", 4'h2, 32'h0, 1'b0, 32'h0, 1'b0); tick("ext");
    push_lit("ext_int_req", 4'h2, 32'h0, 1'b1, 32'h0, 1'b0); tick("ext");
    exc_valid = 1'b1; exc_pc = 32'h00000200; exc_code = 5'h00; tick("ext_exc");
    push_lit("exc_masks_int", 4'hA, 32'h0, 1'b0, 32'h0, 1'b1); tick("ext_exc");
    eret = 1'b1; ext_int = '0; tick("ext_eret");

`ifdef CP0_TLB_EN
    ra = 5'd1;
    mtc0(5'd6, 32'd30, "wr_wired30");
    for (int k = 0; k < 4; k++) begin
      push_lit("random_w30", 4'h1, (k % 2 == 0) ? 32'd31 : 32'd30, 1'b0, 32'h0, 1'b0);
      tick("rnd");
    end
    mtc0(5'd6, 32'd31, "wr_wired31");
    for (int k = 0; k < 3; k++) begin
      push_lit("random_w31", 4'h1, 32'd31, 1'b0, 32'h0, 1'b0);
      tick("rnd");
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      ra = 5'($urandom_range(0, 31));
      if (TlbEn && (ra inside {5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd10})) ra = 5'd13;
      if ($urandom_range(0, 9) < 3) begin
        sel = $urandom_range(0, 9);
        we = 1'b1;
        wdata = $urandom;
        case (sel)
          0: wa = 5'd9;
          1: begin wa = 5'd11; wdata = m_cnt + 32'($urandom_range(0, 6)); end
          2, 3: wa = 5'd12;
          4: wa = 5'd13;
          5: wa = 5'd14;
          6: wa = 5'd16;
          7: wa = 5'd8;
          default: wa = 5'($urandom_range(0, 31));
        endcase
      end
      if ($urandom_range(0, 19) == 0) begin
        exc_valid = 1'b1; exc_code = 5'($urandom); exc_pc = $urandom;
        exc_bd = 1'($urandom); exc_bva_valid = 1'($urandom); exc_badvaddr = $urandom;
      end
      if ($urandom_range(0, 15) == 0) eret = 1'b1;
      if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick("rand");
    end
    reset = 1'b0;
    chk_en = 1'b0;

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d pending, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
